// File: rtl/time_config_if.sv
// -----------------------------------------------------------------------------
// time_config_if
//   Bundles the button pulses, the seed time values and the edit-session
//   outputs of time_config.
//
//   Signal semantics: every btn_* is a one-cycle pulse from the debouncer and
//   needs no acknowledge. load_clock / load_alarm are one-cycle strobes, and
//   the receiver must capture conf_time in the cycle that the strobe is high.
//   conf_pulse is high in the first cycle of any new conf_time/conf_stat value.
//
//   master : button/time source (upstream logic or testbench)
//   slave  : time_config
// -----------------------------------------------------------------------------
interface time_config_if;
    logic        btn_mode;
    logic        btn_next;
    logic        btn_inc;
    logic        btn_dec;
    logic [23:0] clock_time;
    logic [23:0] alarm_time;
    logic [1:0]  conf_stat;
    logic [23:0] conf_time;
    logic        conf_pulse;
    logic [1:0]  field_sel;
    logic        load_clock;
    logic        load_alarm;

    modport master (
        output btn_mode, btn_next, btn_inc, btn_dec, clock_time, alarm_time,
        input  conf_stat, conf_time, conf_pulse, field_sel, load_clock, load_alarm
    );

    modport slave (
        input  btn_mode, btn_next, btn_inc, btn_dec, clock_time, alarm_time,
        output conf_stat, conf_time, conf_pulse, field_sel, load_clock, load_alarm
    );
endinterface

// File: rtl/time_config.sv
// -----------------------------------------------------------------------------
// time_config
//   Button-driven time/alarm editor. mode enters a time edit, switches to an
//   alarm edit, then aborts. next walks hour -> minute -> second and commits
//   after the second field. inc/dec change the selected packed-BCD field
//   with wrap-around.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : synchronous active-low reset
//     bus    : time_config_if.slave (buttons, seed times, session outputs)
//
//   The state register is visible directly as bus.conf_stat.
//   The outputs are all registered, so the latency is one cycle.
//
//   Optional feature: define CONF_TIMEOUT_EN to build an inactivity counter.
//   This counter aborts a session after TIMEOUT_CYCLES cycles with no button.
// -----------------------------------------------------------------------------
module time_config #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    time_config_if.slave  bus
);

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_SET_TIME  = 2'b01;
    localparam logic [1:0] ST_SET_ALARM = 2'b10;

    localparam logic [1:0] FLD_HOUR = 2'b00;
    localparam logic [1:0] FLD_MIN  = 2'b01;
    localparam logic [1:0] FLD_SEC  = 2'b10;

    logic [1:0]  state;
    logic [23:0] conf_time;
    logic        conf_pulse;
    logic [1:0]  field_sel;
    logic        load_clock;
    logic        load_alarm;
    logic        any_btn;
    logic        timeout_hit;

    assign any_btn = bus.btn_mode | bus.btn_next | bus.btn_inc | bus.btn_dec;

    // BCD increment that wraps from top back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == top)             r = 8'h00;
        else if (v[3:0] == 4'h9)  r = {v[7:4] + 4'd1, 4'h0};
        else                      r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // BCD decrement that wraps from 00 up to top.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        logic [7:0] r;
        if (v == 8'h00)           r = top;
        else if (v[3:0] == 4'h0)  r = {v[7:4] - 4'd1, 4'h9};
        else                      r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // Change only the selected field. The other fields pass through unchanged.
    function automatic logic [23:0] edit_field(input logic [23:0] t,
                                               input logic [1:0]  f,
                                               input logic        up);
        logic [23:0] r;
        r = t;
        case (f)
            FLD_HOUR: r[23:16] = up ? bcd_inc(t[23:16], 8'h23) : bcd_dec(t[23:16], 8'h23);
            FLD_MIN:  r[15:8]  = up ? bcd_inc(t[15:8],  8'h59) : bcd_dec(t[15:8],  8'h59);
            FLD_SEC:  r[7:0]   = up ? bcd_inc(t[7:0],   8'h59) : bcd_dec(t[7:0],   8'h59);
            default:  r = t;
        endcase
        return r;
    endfunction

`ifdef CONF_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // The counter holds the number of idle edges since the last button press or
    // state entry. The abort happens on the TIMEOUT_CYCLES-th idle edge.
    assign timeout_hit = (state != ST_IDLE) && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_IDLE || any_btn || timeout_hit) begin
            idle_cnt <= 32'd0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            conf_time  <= 24'h000000;
            conf_pulse <= 1'b0;
            field_sel  <= FLD_HOUR;
            load_clock <= 1'b0;
            load_alarm <= 1'b0;
        end else begin
            conf_pulse <= 1'b0;
            load_clock <= 1'b0;
            load_alarm <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.btn_mode) begin
                        state      <= ST_SET_TIME;
                        conf_time  <= bus.clock_time;
                        field_sel  <= FLD_HOUR;
                        conf_pulse <= 1'b1;
                    end
                end
                ST_SET_TIME, ST_SET_ALARM: begin
                    if (bus.btn_mode) begin
                        // Switching to the alarm discards the time edit. From the alarm, mode aborts.
                        if (state == ST_SET_TIME) begin
                            state     <= ST_SET_ALARM;
                            conf_time <= bus.alarm_time;
                        end else begin
                            state     <= ST_IDLE;
                        end
                        field_sel  <= FLD_HOUR;
                        conf_pulse <= 1'b1;
                    end else if (bus.btn_next) begin
                        if (field_sel == FLD_SEC) begin
                            // Commit. conf_time keeps the committed value while the strobe is high.
                            load_clock <= (state == ST_SET_TIME);
                            load_alarm <= (state == ST_SET_ALARM);
                            state      <= ST_IDLE;
                            field_sel  <= FLD_HOUR;
                            conf_pulse <= 1'b1;
                        end else begin
                            field_sel  <= field_sel + 2'd1;
                        end
                    end else if (bus.btn_inc) begin
                        conf_time  <= edit_field(conf_time, field_sel, 1'b1);
                        conf_pulse <= 1'b1;
                    end else if (bus.btn_dec) begin
                        conf_time  <= edit_field(conf_time, field_sel, 1'b0);
                        conf_pulse <= 1'b1;
                    end else if (timeout_hit) begin
                        state      <= ST_IDLE;
                        field_sel  <= FLD_HOUR;
                        conf_pulse <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    field_sel <= FLD_HOUR;
                end
            endcase
        end
    end

    assign bus.conf_stat  = state;
    assign bus.conf_time  = conf_time;
    assign bus.conf_pulse = conf_pulse;
    assign bus.field_sel  = field_sel;
    assign bus.load_clock = load_clock;
    assign bus.load_alarm = load_alarm;

endmodule

// File: tb/tb_time_config.sv
// -----------------------------------------------------------------------------
// tb_time_config
//   Testbench for time_config, driven from a table of vectors. Each vector
//   holds reset, buttons, seed times and the outputs expected after the next
//   edge. Expected output words are pushed into exp_q when a vector is driven,
//   then popped and compared 1 time unit after the rising edge. A hand-written
//   sequence at the end covers the session-length behaviour, either the
//   inactivity timeout or an unlimited session.
// -----------------------------------------------------------------------------
module tb_time_config;

    localparam int W = 31;  // {stat[2], time[24], pulse, field[2], load_clock, load_alarm}

    typedef struct {
        logic         rst_n;
        logic [3:0]   btn;   // {mode, next, inc, dec}
        logic [23:0]  ct;
        logic [23:0]  at;
        logic [W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[$];

    time_config_if bus ();

    time_config #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic vec_t mk(input logic r, input logic [3:0] b,
                                input logic [23:0] ct, input logic [23:0] at,
                                input logic [1:0] st, input logic [23:0] tm,
                                input logic p, input logic [1:0] f,
                                input logic lc, input logic la);
        vec_t v;
        v.rst_n = r;
        v.btn   = b;
        v.ct    = ct;
        v.at    = at;
        v.exp   = {st, tm, p, f, lc, la};
        return v;
    endfunction

    // Drive one cycle, push its expectation, then check it after the edge.
    task automatic apply(input int idx, input vec_t v);
        logic [W-1:0] got;
        logic [W-1:0] want;
        @(negedge clk);
        rst_n          = v.rst_n;
        bus.btn_mode   = v.btn[3];
        bus.btn_next   = v.btn[2];
        bus.btn_inc    = v.btn[1];
        bus.btn_dec    = v.btn[0];
        bus.clock_time = v.ct;
        bus.alarm_time = v.at;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        got  = {bus.conf_stat, bus.conf_time, bus.conf_pulse, bus.field_sel,
                bus.load_clock, bus.load_alarm};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step[%0d] outputs: got stat=%b time=%h pulse=%b field=%b lc=%b la=%b, expected stat=%b time=%h pulse=%b field=%b lc=%b la=%b",
                     idx, got[30:29], got[28:5], got[4], got[3:2], got[1], got[0],
                     want[30:29], want[28:5], want[4], want[3:2], want[1], want[0]);
        end
    endtask

    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_MODE = 4'b1000;
    localparam logic [3:0] B_NEXT = 4'b0100;
    localparam logic [3:0] B_INC  = 4'b0010;
    localparam logic [3:0] B_DEC  = 4'b0001;

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.btn_mode = 1'b0; bus.btn_next = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
        bus.clock_time = 24'h0; bus.alarm_time = 24'h0;

        // reset and idle
        vecs.push_back(mk(0, B_NONE, 24'h000000, 24'h000000, 2'b00, 24'h000000, 0, 2'b00, 0, 0));
        vecs.push_back(mk(0, B_NONE, 24'h000000, 24'h000000, 2'b00, 24'h000000, 0, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NONE, 24'h000000, 24'h000000, 2'b00, 24'h000000, 0, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h000000, 24'h000000, 2'b00, 24'h000000, 0, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h000000, 24'h000000, 2'b00, 24'h000000, 0, 2'b00, 0, 0));
        // time commit
        vecs.push_back(mk(1, B_MODE, 24'h125930, 24'h000000, 2'b01, 24'h125930, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h125930, 24'h000000, 2'b01, 24'h135930, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h125930, 24'h000000, 2'b01, 24'h135930, 0, 2'b01, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h125930, 24'h000000, 2'b01, 24'h135930, 0, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h125930, 24'h000000, 2'b01, 24'h135929, 1, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h125930, 24'h000000, 2'b00, 24'h135929, 1, 2'b00, 1, 0));
        vecs.push_back(mk(1, B_NONE, 24'h125930, 24'h000000, 2'b00, 24'h135929, 0, 2'b00, 0, 0));
        // wrap-around
        vecs.push_back(mk(1, B_MODE, 24'h235900, 24'h000000, 2'b01, 24'h235900, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h235900, 24'h000000, 2'b01, 24'h005900, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h235900, 24'h000000, 2'b01, 24'h235900, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h235900, 24'h000000, 2'b01, 24'h235900, 0, 2'b01, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h235900, 24'h000000, 2'b01, 24'h230000, 1, 2'b01, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h235900, 24'h000000, 2'b01, 24'h230000, 0, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h235900, 24'h000000, 2'b01, 24'h230059, 1, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h235900, 24'h000000, 2'b01, 24'h230000, 1, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h235900, 24'h000000, 2'b00, 24'h230000, 1, 2'b00, 1, 0));
        // nibble carry/borrow, priority among next/inc/dec
        vecs.push_back(mk(1, B_MODE, 24'h120910, 24'h000000, 2'b01, 24'h120910, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h120910, 24'h000000, 2'b01, 24'h120910, 0, 2'b01, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h120910, 24'h000000, 2'b01, 24'h121010, 1, 2'b01, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h120910, 24'h000000, 2'b01, 24'h120910, 1, 2'b01, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h120910, 24'h000000, 2'b01, 24'h120810, 1, 2'b01, 0, 0));
        vecs.push_back(mk(1, 4'b0111,24'h120910, 24'h000000, 2'b01, 24'h120810, 0, 2'b10, 0, 0));
        vecs.push_back(mk(1, 4'b0011,24'h120910, 24'h000000, 2'b01, 24'h120811, 1, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h120910, 24'h000000, 2'b01, 24'h120810, 1, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h120910, 24'h000000, 2'b01, 24'h120809, 1, 2'b10, 0, 0));
        // mode+inc switches with no increment; alarm seed sampled only at the switch; abort
        vecs.push_back(mk(1, 4'b1010,24'h120910, 24'h063000, 2'b10, 24'h063000, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h120910, 24'h111111, 2'b10, 24'h073000, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_MODE, 24'h120910, 24'h111111, 2'b00, 24'h073000, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NONE, 24'h120910, 24'h111111, 2'b00, 24'h073000, 0, 2'b00, 0, 0));
        // alarm commit
        vecs.push_back(mk(1, B_MODE, 24'h000000, 24'h095959, 2'b01, 24'h000000, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h000000, 24'h095959, 2'b01, 24'h230000, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_MODE, 24'h000000, 24'h095959, 2'b10, 24'h095959, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h000000, 24'h095959, 2'b10, 24'h105959, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_DEC,  24'h000000, 24'h095959, 2'b10, 24'h095959, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h000000, 24'h095959, 2'b10, 24'h095959, 0, 2'b01, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h000000, 24'h095959, 2'b10, 24'h090059, 1, 2'b01, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h000000, 24'h095959, 2'b10, 24'h090059, 0, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_INC,  24'h000000, 24'h095959, 2'b10, 24'h090000, 1, 2'b10, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h000000, 24'h095959, 2'b00, 24'h090000, 1, 2'b00, 0, 1));
        vecs.push_back(mk(1, B_NONE, 24'h000000, 24'h095959, 2'b00, 24'h090000, 0, 2'b00, 0, 0));
        // reset mid-edit
        vecs.push_back(mk(1, B_MODE, 24'h010203, 24'h000000, 2'b01, 24'h010203, 1, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NEXT, 24'h010203, 24'h000000, 2'b01, 24'h010203, 0, 2'b01, 0, 0));
        vecs.push_back(mk(0, B_INC,  24'h010203, 24'h000000, 2'b00, 24'h000000, 0, 2'b00, 0, 0));
        vecs.push_back(mk(1, B_NONE, 24'h010203, 24'h000000, 2'b00, 24'h000000, 0, 2'b00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Session length: enter SET_TIME and leave the buttons idle.
        apply(100, mk(1, B_MODE, 24'h111111, 24'h000000, 2'b01, 24'h111111, 1, 2'b00, 0, 0));
`ifdef CONF_TIMEOUT_EN
        for (int i = 1; i <= 7; i++)
            apply(100 + i, mk(1, B_NONE, 24'h111111, 24'h000000, 2'b01, 24'h111111, 0, 2'b00, 0, 0));
        apply(108, mk(1, B_NONE, 24'h111111, 24'h000000, 2'b00, 24'h111111, 1, 2'b00, 0, 0));
        apply(109, mk(1, B_NONE, 24'h111111, 24'h000000, 2'b00, 24'h111111, 0, 2'b00, 0, 0));
        // Re-enter. A button at idle cycle 7 restarts the count.
        apply(110, mk(1, B_MODE, 24'h111111, 24'h000000, 2'b01, 24'h111111, 1, 2'b00, 0, 0));
        for (int i = 1; i <= 6; i++)
            apply(110 + i, mk(1, B_NONE, 24'h111111, 24'h000000, 2'b01, 24'h111111, 0, 2'b00, 0, 0));
        apply(117, mk(1, B_INC, 24'h111111, 24'h000000, 2'b01, 24'h121111, 1, 2'b00, 0, 0));
        for (int i = 1; i <= 7; i++)
            apply(117 + i, mk(1, B_NONE, 24'h111111, 24'h000000, 2'b01, 24'h121111, 0, 2'b00, 0, 0));
        apply(125, mk(1, B_NONE, 24'h111111, 24'h000000, 2'b00, 24'h121111, 1, 2'b00, 0, 0));
`else
        // With no timeout the session stays open however long the buttons are idle.
        for (int i = 1; i <= 30; i++)
            apply(100 + i, mk(1, B_NONE, 24'h111111, 24'h000000, 2'b01, 24'h111111, 0, 2'b00, 0, 0));
        apply(131, mk(1, B_DEC, 24'h111111, 24'h000000, 2'b01, 24'h101111, 1, 2'b00, 0, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
